// File: rtl/writeback_arbiter_pkg.sv
// Shared CPU widths and constants for the register-file write side.
// Register 0 is hard-wired and never reserved or written.
package writeback_arbiter_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_REG_W  = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/writeback_arbiter_result_fifo.sv
// Small synchronous FIFO with wrap-around pointers (one extra bit for full/empty).
// The head entry is read combinationally so a pop can be selected in the same cycle.
module writeback_arbiter_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_fire, pop_fire;

    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push_ready = !full;
    assign push_fire  = push_valid && !full;
    assign pop_fire   = pop_req && !empty;
    assign pop_data   = mem[rd_ptr_reg[PTR_W-1:0]];

    assign wr_ptr_next = push_fire ? wr_ptr_reg + (PTR_W+1)'(1) : wr_ptr_reg;
    assign rd_ptr_next = pop_fire  ? rd_ptr_reg + (PTR_W+1)'(1) : rd_ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered load results onto the single register-file write port
// and tracks per-register pending writes for decode hazard detection.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_W          = CPU_DATA_W,
    parameter int REG_W           = CPU_REG_W,
    parameter int LOAD_FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_reg,
    output logic              issue_ready,
    input  logic [REG_W-1:0]  src_a_reg,
    input  logic [REG_W-1:0]  src_b_reg,
    output logic              hazard_a,
    output logic              hazard_b,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [REG_W-1:0]  load_reg,
    input  logic [DATA_W-1:0] load_data,
    output logic              write_back_en,
    output logic [REG_W-1:0]  write_back_reg,
    output logic [DATA_W-1:0] write_back,
    output logic              wb_error
);

    localparam int               NUM_REGS = 2 ** REG_W;
    localparam int               ENTRY_W  = REG_W + DATA_W;
    localparam logic [REG_W-1:0] REG_NONE = REG_W'(REG_ZERO);

    logic [NUM_REGS-1:0] pending_reg, pending_next;
    logic                fifo_full, fifo_empty, fifo_pop;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                sel_valid;
    logic [REG_W-1:0]    sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                issue_fire;
    logic                sel_unreserved;

    writeback_arbiter_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOAD_FIFO_DEPTH)
    ) u_result_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (load_valid),
        .push_ready (load_ready),
        .push_data  ({load_reg, load_data}),
        .pop_req    (fifo_pop),
        .pop_data   (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A full load buffer always drains first so loads cannot be starved by the ALU.
    always_comb begin
        alu_ready = 1'b0;
        fifo_pop  = 1'b0;
        sel_valid = 1'b0;
        sel_reg   = '0;
        sel_data  = '0;
        if (fifo_full) begin
            fifo_pop              = 1'b1;
            sel_valid             = 1'b1;
            {sel_reg, sel_data}   = fifo_head;
        end else if (alu_valid) begin
            alu_ready = 1'b1;
            sel_valid = 1'b1;
            sel_reg   = alu_reg;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            fifo_pop              = 1'b1;
            sel_valid             = 1'b1;
            {sel_reg, sel_data}   = fifo_head;
        end
    end

    assign hazard_a       = pending_reg[src_a_reg];
    assign hazard_b       = pending_reg[src_b_reg];
    assign issue_ready    = !pending_reg[issue_reg];
    assign issue_fire     = issue_valid && issue_ready && (issue_reg != REG_NONE);
    assign sel_unreserved = sel_valid && (sel_reg != REG_NONE) && !pending_reg[sel_reg];

    // Reservation set beats a commit clear on the same edge.
    assign pending_next[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_pending
            logic set_hit, clr_hit;
            assign set_hit = issue_fire && (issue_reg == REG_W'(gi));
            assign clr_hit = write_back_en && (write_back_reg == REG_W'(gi));
            assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_back_en  <= 1'b0;
            write_back_reg <= '0;
            write_back     <= '0;
            wb_error       <= 1'b0;
            pending_reg    <= '0;
        end else begin
            write_back_en <= sel_valid && (sel_reg != REG_NONE);
            if (sel_valid) begin
                write_back_reg <= sel_reg;
                write_back     <= sel_data;
            end
            if (sel_unreserved) begin
                wb_error <= 1'b1;
            end
            pending_reg <= pending_next;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 2;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [REG_W-1:0]  issue_reg;
    logic              issue_ready;
    logic [REG_W-1:0]  src_a_reg, src_b_reg;
    logic              hazard_a, hazard_b;
    logic              alu_valid, alu_ready;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              load_valid, load_ready;
    logic [REG_W-1:0]  load_reg;
    logic [DATA_W-1:0] load_data;
    logic              write_back_en;
    logic [REG_W-1:0]  write_back_reg;
    logic [DATA_W-1:0] write_back;
    logic              wb_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATA_W          (DATA_W),
        .REG_W           (REG_W),
        .LOAD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_reg      (issue_reg),
        .issue_ready    (issue_ready),
        .src_a_reg      (src_a_reg),
        .src_b_reg      (src_b_reg),
        .hazard_a       (hazard_a),
        .hazard_b       (hazard_b),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_reg       (load_reg),
        .load_data      (load_data),
        .write_back_en  (write_back_en),
        .write_back_reg (write_back_reg),
        .write_back     (write_back),
        .wb_error       (wb_error)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_reg = '0;
        src_a_reg   = '0;   src_b_reg = '0;
        alu_valid   = 1'b0; alu_reg   = '0; alu_data  = '0;
        load_valid  = 1'b0; load_reg  = '0; load_data = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue_one(input logic [REG_W-1:0] r);
        issue_valid = 1'b1; issue_reg = r;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        issue_reg = 5'd9; src_a_reg = 5'd9; src_b_reg = 5'd0;
        tick();
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back, wb_error} !== '0)
            $display("FAIL reset_outputs: got en=%0b reg=%0d data=%h err=%0b want all 0",
                     write_back_en, write_back_reg, write_back, wb_error);
        else pass_cnt++;
        total_cnt++;
        if ({load_ready, alu_ready, issue_ready, hazard_a, hazard_b} !== 5'b10100)
            $display("FAIL reset_flags: got lr=%0b ar=%0b ir=%0b ha=%0b hb=%0b want 1 0 1 0 0",
                     load_ready, alu_ready, issue_ready, hazard_a, hazard_b);
        else pass_cnt++;
    endtask

    task automatic test_raw();
        src_a_reg = 5'd5;
        issue_one(5'd5);
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if (hazard_a !== 1'b1) $display("FAIL raw_hazard_after_issue: got %0b want 1", hazard_a);
        else pass_cnt++;
        tick();
        alu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL raw_write: got en=%0b reg=%0d data=%h want 1 5 deadbeef",
                     write_back_en, write_back_reg, write_back);
        else pass_cnt++;
        total_cnt++;
        if (hazard_a !== 1'b1) $display("FAIL raw_hazard_before_commit: got %0b want 1", hazard_a);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({hazard_a, write_back_en, wb_error} !== 3'b000)
            $display("FAIL raw_after_commit: got ha=%0b en=%0b err=%0b want 0 0 0",
                     hazard_a, write_back_en, wb_error);
        else pass_cnt++;
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_reg = 5'd7; src_b_reg = 5'd7;
        #1;
        total_cnt++;
        if (issue_ready !== 1'b1) $display("FAIL waw_first_issue: got %0b want 1", issue_ready);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (issue_ready !== 1'b0) $display("FAIL waw_second_issue: got %0b want 0", issue_ready);
        else pass_cnt++;
        tick();
        issue_reg = 5'd0; src_a_reg = 5'd0;
        #1;
        total_cnt++;
        if (issue_ready !== 1'b1) $display("FAIL waw_issue_r0: got %0b want 1", issue_ready);
        else pass_cnt++;
        tick();
        issue_valid = 1'b0;
        #1;
        total_cnt++;
        if ({hazard_a, hazard_b} !== 2'b01)
            $display("FAIL waw_hazards: got ha=%0b hb=%0b want 0 1", hazard_a, hazard_b);
        else pass_cnt++;
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        tick();
        #1;
        total_cnt++;
        if ({hazard_b, wb_error} !== 2'b00)
            $display("FAIL waw_cleared: got hb=%0b err=%0b want 0 0", hazard_b, wb_error);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        issue_one(5'd3);
        issue_one(5'd4);
        load_valid = 1'b1; load_reg = 5'd3; load_data = 32'h11;
        alu_valid  = 1'b1; alu_reg  = 5'd4; alu_data  = 32'h22;
        #1;
        total_cnt++;
        if ({alu_ready, load_ready} !== 2'b11)
            $display("FAIL coll_ready: got ar=%0b lr=%0b want 1 1", alu_ready, load_ready);
        else pass_cnt++;
        tick();
        load_valid = 1'b0; alu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back} !== {1'b1, 5'd4, 32'h22})
            $display("FAIL coll_alu_first: got en=%0b reg=%0d data=%h want 1 4 22",
                     write_back_en, write_back_reg, write_back);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL coll_load_second: got en=%0b reg=%0d data=%h want 1 3 11",
                     write_back_en, write_back_reg, write_back);
        else pass_cnt++;
        tick();
        src_a_reg = 5'd3; src_b_reg = 5'd4;
        #1;
        total_cnt++;
        if ({hazard_a, hazard_b, wb_error} !== 3'b000)
            $display("FAIL coll_cleared: got ha=%0b hb=%0b err=%0b want 0 0 0",
                     hazard_a, hazard_b, wb_error);
        else pass_cnt++;
    endtask

    task automatic test_fifo_full();
        issue_one(5'd8); issue_one(5'd9); issue_one(5'd10);
        issue_one(5'd11); issue_one(5'd13);
        load_valid = 1'b1; load_reg = 5'd8;  load_data = 32'hA8;
        alu_valid  = 1'b1; alu_reg  = 5'd10; alu_data  = 32'hAA;
        tick();
        load_reg = 5'd9; load_data = 32'hA9;
        alu_reg  = 5'd11; alu_data = 32'hAB;
        #1;
        total_cnt++;
        if ({alu_ready, load_ready} !== 2'b11)
            $display("FAIL full_one_entry: got ar=%0b lr=%0b want 1 1", alu_ready, load_ready);
        else pass_cnt++;
        tick();
        load_valid = 1'b0;
        alu_reg = 5'd13; alu_data = 32'hAD;
        #1;
        total_cnt++;
        if ({alu_ready, load_ready} !== 2'b00)
            $display("FAIL full_stall: got ar=%0b lr=%0b want 0 0", alu_ready, load_ready);
        else pass_cnt++;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back} !== {1'b1, 5'd11, 32'hAB})
            $display("FAIL full_wb_alu11: got en=%0b reg=%0d data=%h want 1 11 ab",
                     write_back_en, write_back_reg, write_back);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back, alu_ready} !== {1'b1, 5'd8, 32'hA8, 1'b1})
            $display("FAIL full_wb_load8: got en=%0b reg=%0d data=%h ar=%0b want 1 8 a8 1",
                     write_back_en, write_back_reg, write_back, alu_ready);
        else pass_cnt++;
        tick();
        alu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back} !== {1'b1, 5'd13, 32'hAD})
            $display("FAIL full_wb_alu13: got en=%0b reg=%0d data=%h want 1 13 ad",
                     write_back_en, write_back_reg, write_back);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back} !== {1'b1, 5'd9, 32'hA9})
            $display("FAIL full_wb_load9: got en=%0b reg=%0d data=%h want 1 9 a9",
                     write_back_en, write_back_reg, write_back);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({write_back_en, wb_error} !== 2'b00)
            $display("FAIL full_drained: got en=%0b err=%0b want 0 0", write_back_en, wb_error);
        else pass_cnt++;
    endtask

    task automatic test_error();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({write_back_en, wb_error} !== 2'b00)
            $display("FAIL err_reg0: got en=%0b err=%0b want 0 0", write_back_en, wb_error);
        else pass_cnt++;
        alu_valid = 1'b1; alu_reg = 5'd12; alu_data = 32'h12C;
        tick();
        alu_valid = 1'b0;
        #1;
        total_cnt++;
        if ({write_back_en, write_back_reg, write_back, wb_error} !== {1'b1, 5'd12, 32'h12C, 1'b1})
            $display("FAIL err_unreserved: got en=%0b reg=%0d data=%h err=%0b want 1 12 12c 1",
                     write_back_en, write_back_reg, write_back, wb_error);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (wb_error !== 1'b1) $display("FAIL err_sticky: got %0b want 1", wb_error);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (wb_error !== 1'b0) $display("FAIL err_cleared_by_rst: got %0b want 0", wb_error);
        else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        src_a_reg = 5'd6;
        issue_one(5'd6);
        alu_valid  = 1'b1; alu_reg  = 5'd0; alu_data  = 32'h1;
        load_valid = 1'b1; load_reg = 5'd6; load_data = 32'h66;
        tick(); tick();
        idle_inputs();
        src_a_reg = 5'd6;
        #1;
        total_cnt++;
        if ({load_ready, hazard_a} !== 2'b01)
            $display("FAIL mid_before_rst: got lr=%0b ha=%0b want 0 1", load_ready, hazard_a);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({load_ready, hazard_a} !== 2'b10)
            $display("FAIL mid_async_rst: got lr=%0b ha=%0b want 1 0", load_ready, hazard_a);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({write_back_en, wb_error} !== 2'b00)
            $display("FAIL mid_fifo_discarded: got en=%0b err=%0b want 0 0", write_back_en, wb_error);
        else pass_cnt++;
    endtask

    typedef struct packed {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } ent_t;

    task automatic test_random();
        ent_t              q[$];
        logic              pend [NREG];
        logic              m_en, m_err, hold;
        logic [REG_W-1:0]  m_reg;
        logic [DATA_W-1:0] m_data;
        logic              full, exp_ar, exp_ir, sel;
        ent_t              pick;
        pulse_reset();
        for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
        m_en = 1'b0; m_err = 1'b0; m_reg = '0; m_data = '0; hold = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            total_cnt++;
            if (write_back_en !== m_en || wb_error !== m_err)
                $display("FAIL rnd_regs cyc %0d: got en=%0b err=%0b want %0b %0b",
                         cyc, write_back_en, wb_error, m_en, m_err);
            else pass_cnt++;
            if (m_en) begin
                total_cnt++;
                if (write_back_reg !== m_reg || write_back !== m_data)
                    $display("FAIL rnd_wb cyc %0d: got reg=%0d data=%h want %0d %h",
                             cyc, write_back_reg, write_back, m_reg, m_data);
                else pass_cnt++;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_reg   = 5'($urandom_range(0, 7));
            src_a_reg   = 5'($urandom_range(0, 7));
            src_b_reg   = 5'($urandom_range(0, 7));
            if (!hold) begin
                alu_valid = ($urandom_range(0, 2) == 0);
                alu_reg   = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            load_valid = 1'($urandom_range(0, 1));
            load_reg   = 5'($urandom_range(0, 7));
            load_data  = $urandom;
            #1;
            full   = (q.size() == DEPTH);
            exp_ar = alu_valid && !full;
            exp_ir = (issue_reg == 0) || !pend[issue_reg];
            total_cnt++;
            if (alu_ready !== exp_ar || load_ready !== !full || issue_ready !== exp_ir)
                $display("FAIL rnd_ready cyc %0d: got ar=%0b lr=%0b ir=%0b want %0b %0b %0b",
                         cyc, alu_ready, load_ready, issue_ready, exp_ar, !full, exp_ir);
            else pass_cnt++;
            total_cnt++;
            if (hazard_a !== (src_a_reg != 0 && pend[src_a_reg]) ||
                hazard_b !== (src_b_reg != 0 && pend[src_b_reg]))
                $display("FAIL rnd_hazard cyc %0d: got ha=%0b hb=%0b want %0b %0b", cyc,
                         hazard_a, hazard_b, pend[src_a_reg], pend[src_b_reg]);
            else pass_cnt++;
            // Advance the model across the coming edge.
            sel = 1'b1;
            if (full) pick = q.pop_front();
            else if (alu_valid) pick = '{r: alu_reg, d: alu_data};
            else if (q.size() > 0) pick = q.pop_front();
            else sel = 1'b0;
            if (load_valid && !full) q.push_back('{r: load_reg, d: load_data});
            if (sel && pick.r != 0 && !pend[pick.r]) m_err = 1'b1;
            if (m_en) pend[m_reg] = 1'b0;
            if (issue_valid && exp_ir && issue_reg != 0) pend[issue_reg] = 1'b1;
            m_en = sel && pick.r != 0;
            if (sel) begin
                m_reg  = pick.r;
                m_data = pick.d;
            end
            hold = alu_valid && !exp_ar;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_raw();
        test_waw();
        test_collision();
        test_fifo_full();
        test_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Write-side owner of the CPU register file. It merges ALU results and variable-latency load results into the register file's single write port. It also keeps a per-register pending scoreboard so that decode can stall on RAW and WAW hazards. Sits between the execute/memory stages and the register file's write_back_en / write_back_reg / write_back inputs.

Parameters:
DATA_W, 32, register and result data width
REG_W, 5, register index width (2**REG_W registers)
LOAD_FIFO_DEPTH, 2, load-result buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
issue_valid  input  1  decode issues an instruction with a destination
issue_reg  input  REG_W  destination register being reserved
issue_ready  output  1  destination may be reserved (no WAW)
src_a_reg  input  REG_W  decode source A index
src_b_reg  input  REG_W  decode source B index
hazard_a  output  1  source A has a pending write
hazard_b  output  1  source B has a pending write
alu_valid  input  1  ALU result available
alu_ready  output  1  ALU result accepted this cycle
alu_reg  input  REG_W  ALU destination
alu_data  input  DATA_W  ALU result
load_valid  input  1  load result available
load_ready  output  1  load FIFO not full
load_reg  input  REG_W  load destination
load_data  input  DATA_W  load result
write_back_en  output  1  register file write enable
write_back_reg  output  REG_W  register file write index
write_back  output  DATA_W  register file write data
wb_error  output  1  sticky: result arrived for a non-pending register

Behaviour:
- Reset values: write_back_en=0, write_back_reg=0, write_back=0, wb_error=0, FIFO empty, all pending bits 0.
- Reset mid-operation discards FIFO contents and reservations immediately.
- Scoreboard: one pending bit per register. Register 0 never gets a pending bit.
- hazard_x = pending[src_x_reg]. This is combinational; the value for index 0 is always 0.
- issue_ready = !pending[issue_reg]. It is combinational and is always 1 for register 0.
- The pending bit is set at the posedge where issue_valid && issue_ready && issue_reg!=0.
- The pending bit is cleared at the posedge where write_back_en=1 for that register, i.e. the edge on which the register file commits.
- If a set and a clear for the same register fall on the same edge, the set wins.
- Load path: a load is accepted when load_valid && load_ready. Accepted loads are pushed into the FIFO.
- load_ready = FIFO not full. There is no pass-through when full, even if the FIFO pops that cycle.
- Arbitration (per cycle):
  - FIFO full: the FIFO pops, and alu_ready=0.
  - Otherwise, if alu_valid: the ALU is selected and alu_ready=1.
  - Otherwise, if the FIFO is non-empty: the FIFO pops.
  - Otherwise: idle.
- alu_ready is combinational. The ALU producer must hold alu_reg and alu_data while alu_valid && !alu_ready.
- Output register: the selected result is registered into write_back_reg and write_back.
- write_back_en=1 on the next edge only if the destination is not 0. A result addressed to 0 is consumed with write_back_en=0.
- Latency: ALU result to write_back_en is 1 cycle. Load accept to write_back_en is 2 cycles minimum.
- Simultaneous FIFO push and pop in the same cycle is legal. Occupancy is unchanged.
- The FIFO uses wrap-around pointers with one extra bit for the full/empty distinction.
- wb_error is set when a selected result targets a register other than 0 whose pending bit is 0. It stays set until rst.

Decomposition:
- Shared CPU package holds the widths (DATA_W, REG_W) and the constant REG_ZERO=0.
- One natural sub-module: result_fifo, a parameterised sync FIFO with valid/ready on push, pop on request, and full/empty flags.
- The scoreboard and arbiter stay in the top module.

Test Plan:
- Reset, then idle → all outputs 0. Assert rst mid-FIFO-fill → FIFO empty and pending cleared in the same cycle.
- Issue reg 5; ALU result (5, 0xDEADBEEF) one cycle later:
  - write_back_en=1, write_back_reg=5, write_back=0xDEADBEEF one cycle after the result.
  - hazard_a (src_a_reg=5) high from issue until the commit edge, low afterwards.
- Issue reg 7, then issue reg 7 again before writeback → second issue sees issue_ready=0. Issue reg 0 → issue_ready=1 and hazard stays 0.
- Issue reg 3 and reg 4. Load (3, 0x11) and ALU (4, 0x22) valid in the same cycle:
  - ALU written first, load the following cycle.
  - Both pending bits clear.
- Fill the FIFO with two loads (regs 8 and 9) while alu_valid is held high:
  - load_ready=0 and alu_ready=0 while the FIFO is full.
  - Reg 8 is written next; the ALU result follows once the FIFO is no longer full.
  - Data order is preserved.
- ALU result to unreserved reg 12 → write occurs and wb_error=1, sticky until rst. Result to reg 0 → write_back_en=0 and wb_error stays 0.
